ysyx_23060025_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares one memory-side request/response port among NR_REQ

---
 rtl/ysyx_23060025_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_ysyx_23060025_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_bus_arbiter.sv
// Round-robin arbiter that shares one memory request/response port among NR_REQ masters.
// It allows one outstanding transaction and forwards the single response to the granted master.
module ysyx_23060025_bus_arbiter #(
  parameter int NR_REQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR_REQ-1:0]        m_req_valid,
  output logic [NR_REQ-1:0]        m_req_ready,
  input  logic [NR_REQ-1:0]        m_req_wen,
  input  logic [NR_REQ*ADDR_W-1:0] m_req_addr,
  input  logic [NR_REQ*DATA_W-1:0] m_req_wdata,
  output logic [NR_REQ-1:0]        m_resp_valid,
  output logic [DATA_W-1:0]        m_resp_rdata,
  output logic                     s_req_valid,
  input  logic                     s_req_ready,
  output logic                     s_req_wen,
  output logic [ADDR_W-1:0]        s_req_addr,
  output logic [DATA_W-1:0]        s_req_wdata,
  input  logic                     s_resp_valid,
  input  logic [DATA_W-1:0]        s_resp_rdata,
  output logic [NR_REQ-1:0]        grant,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NR_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [NR_REQ-1:0] grant_oh;
  logic              g_valid;

  assign grant_oh = NR_REQ'(1) << gidx_q;
  assign g_valid  = |(m_req_valid & grant_oh);

  // First requester at or after last+1, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i + 1) % NR_REQ);
      if (!pick_found && m_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NR_REQ - 1);
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (g_valid && s_req_ready) state_d = WAIT_RESP;
        else if (!g_valid)          state_d = IDLE;
      end
      WAIT_RESP: begin
        if (s_resp_valid) begin
          last_d  = gidx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_req_ready  = '0;
    m_resp_valid = '0;
    m_resp_rdata = s_resp_rdata;
    s_req_valid  = 1'b0;
    s_req_wen    = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    grant        = '0;
    busy         = 1'b0;
    case (state_q)
      ISSUE: begin
        grant       = grant_oh;
        busy        = 1'b1;
        s_req_valid = g_valid;
        m_req_ready = grant_oh & {NR_REQ{s_req_ready}};
        s_req_wen   = m_req_wen[gidx_q];
        s_req_addr  = ADDR_W'(m_req_addr >> (ADDR_W * int'(gidx_q)));
        s_req_wdata = DATA_W'(m_req_wdata >> (DATA_W * int'(gidx_q)));
      end
      WAIT_RESP: begin
        grant        = grant_oh;
        busy         = 1'b1;
        m_resp_valid = grant_oh & {NR_REQ{s_resp_valid}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_bus_arbiter.sv
// Bench for ysyx_23060025_bus_arbiter: directed scenarios followed by random traffic.
// All outputs are compared each cycle against a transaction-level reference model.
module tb_ysyx_23060025_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    m_valid, m_ready, m_wen, m_rvalid;
  logic [NR*AW-1:0] m_addr;
  logic [NR*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             s_valid, s_ready, s_wen, s_rvalid;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata, s_rdata;
  logic [NR-1:0]    grant;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0 = no owner, 1 = owner presenting request, 2 = owner awaiting data
  int ms, mg, mlast;

  always #5 clk = ~clk;

  ysyx_23060025_bus_arbiter #(.NR_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_valid), .m_req_ready(m_ready), .m_req_wen(m_wen),
    .m_req_addr(m_addr), .m_req_wdata(m_wdata),
    .m_resp_valid(m_rvalid), .m_resp_rdata(m_rdata),
    .s_req_valid(s_valid), .s_req_ready(s_ready), .s_req_wen(s_wen),
    .s_req_addr(s_addr), .s_req_wdata(s_wdata),
    .s_resp_valid(s_rvalid), .s_resp_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit vbit(input logic [NR-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int d = 1; d <= NR; d++) begin
      int c;
      c = (last + d) % NR;
      if (vbit(v, c)) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    ms = 0; mg = 0; mlast = NR - 1;
  endtask

  task automatic idle_inputs();
    m_valid = '0; m_wen = '0; m_addr = '0; m_wdata = '0;
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  // Compare every DUT output against the model shortly after inputs settle.
  task automatic settle(input string tag);
    logic [NR-1:0] eg, erdy, ervld;
    #1;
    eg    = (ms == 0) ? '0 : NR'(1) << mg;
    erdy  = (ms == 1 && s_ready) ? NR'(1) << mg : '0;
    ervld = (ms == 2 && s_rvalid) ? NR'(1) << mg : '0;
    check({tag, ".grant"},  64'(grant),    64'(eg));
    check({tag, ".busy"},   64'(busy),     64'(ms != 0));
    check({tag, ".svalid"}, 64'(s_valid),  64'(ms == 1 && vbit(m_valid, mg)));
    check({tag, ".mready"}, 64'(m_ready),  64'(erdy));
    check({tag, ".swen"},   64'(s_wen),    64'(ms == 1 && vbit(m_wen, mg)));
    check({tag, ".saddr"},  64'(s_addr),   (ms == 1) ? 64'(AW'(m_addr >> (mg * AW))) : 64'd0);
    check({tag, ".swdata"}, 64'(s_wdata),  (ms == 1) ? 64'(DW'(m_wdata >> (mg * DW))) : 64'd0);
    check({tag, ".rvalid"}, 64'(m_rvalid), 64'(ervld));
    check({tag, ".rdata"},  64'(m_rdata),  64'(s_rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      case (ms)
        0: if (m_valid != '0) begin mg = pick(m_valid, mlast); ms = 1; end
        1: begin
          if (vbit(m_valid, mg) && s_ready) ms = 2;
          else if (!vbit(m_valid, mg))      ms = 0;
        end
        default: if (s_rvalid) begin mlast = mg; ms = 0; end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    @(negedge clk);
    settle("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    do_reset();

    // 1: single read from master 0
    m_valid = 2'b01; m_addr[31:0] = 32'h8000_0000; s_ready = 1'b1;
    settle("t1.idle"); tick();
    settle("t1.issue");
    check("t1.svalid", 64'(s_valid), 64'd1);
    check("t1.saddr", 64'(s_addr), 64'h8000_0000);
    tick();
    m_valid = '0; s_ready = 1'b0;
    settle("t1.wait"); tick();
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    settle("t1.resp");
    check("t1.rvalid", 64'(m_rvalid), 64'b01);
    check("t1.rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    tick();
    s_rvalid = 1'b0;

    // 2: both masters continuously requesting, immediate responses
    do_reset();
    m_valid = 2'b11; s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h55AA_0001;
    for (int k = 0; k < 12; k++) begin
      settle("t2");
      check("t2.seq", 64'(grant), (k % 3 == 0) ? 64'd0 : (((k / 3) % 2 == 0) ? 64'b01 : 64'b10));
      tick();
    end

    // 3: master 1 write held off by s_req_ready for three cycles
    idle_inputs();
    m_valid = 2'b10; m_wen = 2'b10;
    m_addr[63:32] = 32'h8000_0010; m_wdata[63:32] = 32'h0000_1234;
    m_addr[31:0] = 32'h1111_1111; m_wdata[31:0] = 32'h2222_2222;
    settle("t3.idle"); tick();
    for (int k = 0; k < 3; k++) begin
      settle("t3.stall");
      check("t3.saddr", 64'(s_addr), 64'h8000_0010);
      check("t3.swdata", 64'(s_wdata), 64'h1234);
      check("t3.swen", 64'(s_wen), 64'd1);
      check("t3.mready", 64'(m_ready), 64'd0);
      tick();
    end
    s_ready = 1'b1;
    settle("t3.hs");
    check("t3.mready_hs", 64'(m_ready), 64'b10);
    tick();
    m_valid = '0; s_ready = 1'b0; s_rvalid = 1'b1;
    settle("t3.resp");
    check("t3.rvalid", 64'(m_rvalid), 64'b10);
    tick();
    s_rvalid = 1'b0;

    // 4: master 0 aborts in ISSUE, then keeps priority
    m_valid = 2'b01;
    settle("t4.idle"); tick();
    m_valid = 2'b00;
    settle("t4.abort");
    check("t4.busy_abort", 64'(busy), 64'd1);
    tick();
    m_valid = 2'b11;
    settle("t4.idle2");
    check("t4.back_idle", 64'(busy), 64'd0);
    tick();
    settle("t4.regrant");
    check("t4.grant0", 64'(grant), 64'b01);
    s_ready = 1'b1;
    tick();
    m_valid = '0; s_ready = 1'b0; s_rvalid = 1'b1;
    settle("t4.resp"); tick();

    // 5: spurious response while idle
    idle_inputs();
    s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
    settle("t5.spur");
    check("t5.rvalid", 64'(m_rvalid), 64'd0);
    tick();
    settle("t5.after");
    check("t5.busy", 64'(busy), 64'd0);
    s_rvalid = 1'b0;

    // 6: reset while awaiting a response
    m_valid = 2'b10; s_ready = 1'b1;
    settle("t6.idle"); tick();
    settle("t6.issue"); tick();
    m_valid = '0; s_ready = 1'b0;
    settle("t6.wait");
    check("t6.busy_wait", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    settle("t6.rst");
    check("t6.grant_rst", 64'(grant), 64'd0);
    check("t6.busy_rst", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    s_rvalid = 1'b1;
    settle("t6.late");
    check("t6.late_rvalid", 64'(m_rvalid), 64'd0);
    tick();
    s_rvalid = 1'b0; m_valid = 2'b11;
    settle("t6.req"); tick();
    settle("t6.regrant");
    check("t6.grant0", 64'(grant), 64'b01);
    s_ready = 1'b1; tick();
    m_valid = '0; s_ready = 1'b0; s_rvalid = 1'b1;
    settle("t6.resp"); tick();

    // Random traffic, including aborts and occasional async resets
    for (int k = 0; k < 1500; k++) begin
      m_valid  = NR'($urandom_range(0, 3));
      m_wen    = NR'($urandom);
      m_addr   = {$urandom, $urandom};
      m_wdata  = {$urandom, $urandom};
      s_ready  = ($urandom_range(0, 3) != 0);
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        settle("rnd.rst");
        tick();
        rst_n = 1'b1;
      end else begin
        settle("rnd");
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
